qspi_arb: RTL and testbench

- Arbitrates the single QSPI line-transfer engine among three requesters:
  - I: icache line fill.
  - D: dcache line fill or writeback.
  - X: auxiliary line mover (flush-writer/DMA).
- Sits between the caches and qspi; replaces the ad-hoc combinational req/i_d/write/paddr muxing.
- Holds a grant for a whole line transfer, derives the memory chip-select from rom_mode, and ages waiting requesters so none starves.

---
 rtl/vc_pkg.sv | 34 +++
 rtl/arb_age.sv | 48 ++++
 rtl/qspi_arb.sv | 120 ++++++++++++
 tb/tb_qspi_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// Shared types for the QSPI line-engine arbiter: owner and FSM encodings plus
// the chip-select decode used by the top-level memory mux.
package vc_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_I = 2'd0,
    OWN_D = 2'd1,
    OWN_X = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TURN = 2'd2
  } state_e;

  // rom_mode 11 puts instruction fetches and all reads on chip 1, writes on chip 0
  function automatic logic [1:0] mem_sel(input logic [1:0] rom_mode,
                                         input logic       top,
                                         input logic       is_i,
                                         input logic       write);
    logic [1:0] sel;
    case (rom_mode)
      2'b00:   sel = top ? 2'd2 : 2'd0;
      2'b01:   sel = 2'd0;
      2'b10:   sel = top ? 2'd1 : 2'd0;
      default: sel = (is_i || !write) ? 2'd1 : 2'd0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/arb_age.sv
// Three-way fixed-priority picker (D > I > X) with per-requester saturating wait
// counters; a requester that has waited MAX_WAIT arbitration cycles is promoted.
module arb_age
  import vc_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       arb_en,
  output logic [2:0] win
);

  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       promo;
  logic [2:0]       pool;

  always_comb begin
    promo = '0;
    for (int i = 0; i < 3; i++) begin
      promo[i] = req[i] && (cnt[i] == CNT_W'(MAX_WAIT));
    end
    pool = (|promo) ? promo : req;
    win  = '0;
    if (arb_en) begin
      if (pool[OWN_D])      win[OWN_D] = 1'b1;
      else if (pool[OWN_I]) win[OWN_I] = 1'b1;
      else if (pool[OWN_X]) win[OWN_X] = 1'b1;
    end
  end

  // Counters only advance on arbitration cycles; they hold while the engine is busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || win[i]) begin
          cnt[i] <= '0;
        end else if (arb_en && (cnt[i] != CNT_W'(MAX_WAIT))) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/qspi_arb.sv
// Grants the single QSPI line-transfer engine to icache, dcache or the auxiliary
// mover for a whole line, with a mandatory idle turnaround cycle between owners.
module qspi_arb
  import vc_pkg::*;
#(
  parameter int  PA          = 24,
  parameter int  LINE_LENGTH = 4,
  parameter int  MAX_WAIT    = 15,
  localparam int TW          = PA - $clog2(LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  output logic          i_gnt,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [TW-1:0] d_tag,
  output logic          d_gnt,
  output logic          d_done,
  input  logic          x_req,
  input  logic          x_write,
  input  logic [TW-1:0] x_tag,
  output logic          x_gnt,
  output logic          x_done,
  input  logic [1:0]    rom_mode,
  output logic          q_req,
  output logic          q_i_d,
  output logic          q_write,
  output logic [1:0]    q_mem,
  output logic [TW-1:0] q_paddr,
  input  logic          q_done,
  output logic          busy
);

  state_e     state;
  owner_e     owner;
  logic [2:0] gnt;
  logic [2:0] win;
  logic       arb_en;
  logic       xfer_end;

  assign arb_en   = (state != XFER);
  assign xfer_end = (state == XFER) && q_done;

  arb_age #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk   (clk),
    .reset (reset),
    .req   ({x_req, d_req, i_req}),
    .arb_en(arb_en),
    .win   (win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= OWN_I;
      gnt     <= '0;
      q_req   <= 1'b0;
      q_i_d   <= 1'b0;
      q_write <= 1'b0;
      q_paddr <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE, TURN: begin
          if (|win) begin
            state <= XFER;
            gnt   <= win;
            q_req <= 1'b1;
            busy  <= 1'b1;
            if (win[OWN_D]) begin
              owner   <= OWN_D;
              q_paddr <= d_tag;
              q_write <= d_write;
              q_i_d   <= 1'b0;
            end else if (win[OWN_I]) begin
              owner   <= OWN_I;
              q_paddr <= i_tag;
              q_write <= 1'b0;
              q_i_d   <= 1'b1;
            end else begin
              owner   <= OWN_X;
              q_paddr <= x_tag;
              q_write <= x_write;
              q_i_d   <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          // Requester drops are ignored here; only q_done ends the line
          if (q_done) begin
            state   <= TURN;
            gnt     <= '0;
            q_req   <= 1'b0;
            busy    <= 1'b0;
            q_write <= 1'b0;
            q_i_d   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_gnt  = gnt[OWN_I];
  assign d_gnt  = gnt[OWN_D];
  assign x_gnt  = gnt[OWN_X];
  assign i_done = xfer_end && gnt[OWN_I];
  assign d_done = xfer_end && gnt[OWN_D];
  assign x_done = xfer_end && gnt[OWN_X];

  assign q_mem = q_req ? mem_sel(rom_mode, q_paddr[TW-1], owner == OWN_I, q_write) : 2'd0;

endmodule

// File: tb/tb_qspi_arb.sv
// Bench for qspi_arb: directed scenarios plus randomized traffic against a
// transaction-level model (owner or none, wait ages, priority pick).
module tb_qspi_arb;

  localparam int PA = 24;
  localparam int LL = 4;
  localparam int MW = 15;
  localparam int TW = PA - $clog2(LL);

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, x_req, d_write, x_write, q_done;
  logic [TW-1:0] i_tag, d_tag, x_tag;
  logic [1:0]    rom_mode;
  logic          i_gnt, i_done, d_gnt, d_done, x_gnt, x_done;
  logic          q_req, q_i_d, q_write, busy;
  logic [1:0]    q_mem;
  logic [TW-1:0] q_paddr;

  int checks = 0;
  int errors = 0;

  // Reference model state: current owner (-1 = engine free), latched transfer, ages
  int            m_owner;
  int            m_wait [3];
  logic [TW-1:0] m_tag;
  logic          m_write;
  int            lost_i;

  always #5 clk = ~clk;

  qspi_arb #(.PA(PA), .LINE_LENGTH(LL), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_tag(d_tag), .d_gnt(d_gnt), .d_done(d_done),
    .x_req(x_req), .x_write(x_write), .x_tag(x_tag), .x_gnt(x_gnt), .x_done(x_done),
    .rom_mode(rom_mode), .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write),
    .q_mem(q_mem), .q_paddr(q_paddr), .q_done(q_done), .busy(busy)
  );

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if ((int'(i_gnt) + int'(d_gnt) + int'(x_gnt)) > 1 ||
          (int'(i_done) + int'(d_done) + int'(x_done)) > 1) begin
        errors++;
        $display("FAIL onehot: gnt=%b%b%b done=%b%b%b required at most one high",
                 x_gnt, d_gnt, i_gnt, x_done, d_done, i_done);
      end
    end
  end

  // Priority rank: D first, then I, then X
  function automatic int ord(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
  endfunction

  function automatic int pick(input logic [2:0] r);
    int w = -1;
    for (int k = 0; k < 3; k++)
      if (w < 0 && r[ord(k)] && m_wait[ord(k)] == MW) w = ord(k);
    for (int k = 0; k < 3; k++)
      if (w < 0 && r[ord(k)]) w = ord(k);
    return w;
  endfunction

  function automatic logic [1:0] ref_mem(input logic [1:0] rm, input logic top,
                                         input logic is_i, input logic wr);
    case (rm)
      2'd0:    return top ? 2'd2 : 2'd0;
      2'd1:    return 2'd0;
      2'd2:    return top ? 2'd1 : 2'd0;
      default: return (is_i || !wr) ? 2'd1 : 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_mem();
    if (m_owner < 0) return 2'd0;
    return ref_mem(rom_mode, m_tag[TW-1], m_owner == 0, m_write);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
    m_tag   = '0;
    m_write = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] r;
    int         w;
    r = {x_req, d_req, i_req};
    if (m_owner >= 0) begin
      if (q_done) m_owner = -1;
      for (int i = 0; i < 3; i++) if (!r[i]) m_wait[i] = 0;
    end else begin
      w = pick(r);
      if (r[0] && w != 0) lost_i++;
      for (int i = 0; i < 3; i++) begin
        if (!r[i] || i == w) m_wait[i] = 0;
        else if (m_wait[i] < MW) m_wait[i]++;
      end
      if (w >= 0) begin
        m_owner = w;
        m_tag   = (w == 0) ? i_tag : ((w == 1) ? d_tag : x_tag);
        m_write = (w == 0) ? 1'b0 : ((w == 1) ? d_write : x_write);
      end
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; x_req = 0; d_write = 0; x_write = 0; q_done = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    i_tag = '0; d_tag = '0; x_tag = '0; rom_mode = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({i_gnt, d_gnt, x_gnt, i_done, d_done, x_done} !== 6'b0) begin
      errors++; $display("FAIL reset_gnt_done: got %b required 0", {i_gnt, d_gnt, x_gnt, i_done, d_done, x_done});
    end
    checks++;
    if ({q_req, q_i_d, q_write, busy} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0", {q_req, q_i_d, q_write, busy});
    end
    checks++;
    if (q_mem !== 2'd0 || q_paddr !== '0) begin
      errors++; $display("FAIL reset_addr: q_mem=%0d q_paddr=%h required 0/0", q_mem, q_paddr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_i();
    rom_mode = 2'b01; i_req = 1; i_tag = 22'h12345;
    advance();
    checks++;
    if (i_gnt !== 1 || q_req !== 1 || busy !== 1 || q_i_d !== 1 || q_write !== 0) begin
      errors++; $display("FAIL single_i_grant: gnt=%b req=%b busy=%b i_d=%b wr=%b required 1 1 1 1 0",
                         i_gnt, q_req, busy, q_i_d, q_write);
    end
    checks++;
    if (q_paddr !== 22'h12345 || q_mem !== 2'd0) begin
      errors++; $display("FAIL single_i_addr: q_paddr=%h q_mem=%0d required 12345/0", q_paddr, q_mem);
    end
    i_req = 0;
    repeat (3) advance();
    checks++;
    if (i_done !== 0 || q_req !== 1) begin
      errors++; $display("FAIL single_i_hold: done=%b q_req=%b required 0/1", i_done, q_req);
    end
    q_done = 1; #1;
    checks++;
    if (i_done !== 1) begin
      errors++; $display("FAIL single_i_done: got %b required 1", i_done);
    end
    advance();
    q_done = 0; #1;
    checks++;
    if (q_req !== 0 || i_gnt !== 0 || busy !== 0 || i_done !== 0) begin
      errors++; $display("FAIL single_i_release: q_req=%b gnt=%b busy=%b done=%b required 0",
                         q_req, i_gnt, busy, i_done);
    end
    advance();
  endtask

  task automatic test_d_over_i();
    rom_mode = 2'b00; i_req = 1; i_tag = TW'($urandom);
    d_req = 1; d_write = 1; d_tag = 22'h200000;
    advance();
    checks++;
    if (d_gnt !== 1 || i_gnt !== 0 || q_write !== 1 || q_mem !== 2'd2 || q_paddr !== 22'h200000) begin
      errors++; $display("FAIL d_over_i_grant: d=%b i=%b wr=%b mem=%0d addr=%h required 1 0 1 2 200000",
                         d_gnt, i_gnt, q_write, q_mem, q_paddr);
    end
    d_req = 0;
    repeat (2) advance();
    q_done = 1;
    advance();
    q_done = 0;
    checks++;
    if (q_req !== 0 || i_gnt !== 0) begin
      errors++; $display("FAIL d_over_i_turn: q_req=%b i_gnt=%b required 0/0", q_req, i_gnt);
    end
    advance();
    checks++;
    if (i_gnt !== 1 || q_i_d !== 1 || q_paddr !== m_tag) begin
      errors++; $display("FAIL d_over_i_second: i_gnt=%b i_d=%b addr=%h required 1 1 %h",
                         i_gnt, q_i_d, q_paddr, m_tag);
    end
    i_req = 0; q_done = 1;
    advance();
    q_done = 0;
    advance();
  endtask

  task automatic test_starvation();
    int iter = 0;
    i_req = 1; d_req = 1; d_write = 0; lost_i = 0;
    advance();
    while (i_gnt !== 1 && iter < 40) begin
      checks++;
      if (d_gnt !== 1) begin
        errors++; $display("FAIL starve_d_owner: d_gnt=%b required 1", d_gnt);
      end
      q_done = 1; advance();
      q_done = 0; advance();
      iter++;
    end
    checks++;
    if (i_gnt !== 1) begin
      errors++; $display("FAIL starve_timeout: i never granted after %0d rounds", iter);
    end
    checks++;
    if (lost_i != MW) begin
      errors++; $display("FAIL starve_losses: I lost %0d arbitrations required %0d", lost_i, MW);
    end
    // I's age has cleared, so D wins the very next arbitration
    q_done = 1; advance();
    q_done = 0; advance();
    checks++;
    if (d_gnt !== 1 || i_gnt !== 0) begin
      errors++; $display("FAIL starve_clear: d_gnt=%b i_gnt=%b required 1/0", d_gnt, i_gnt);
    end
    i_req = 0; d_req = 0; q_done = 1;
    advance();
    q_done = 0;
    advance();
  endtask

  task automatic test_rom11();
    rom_mode = 2'b11; x_req = 1; x_write = 1; x_tag = TW'($urandom) | 22'h200000;
    advance();
    checks++;
    if (x_gnt !== 1 || q_mem !== 2'd0 || q_write !== 1) begin
      errors++; $display("FAIL rom11_x: x_gnt=%b mem=%0d wr=%b required 1 0 1", x_gnt, q_mem, q_write);
    end
    x_req = 0; d_req = 1; d_write = 0; d_tag = TW'($urandom); q_done = 1;
    advance();
    q_done = 0;
    advance();
    checks++;
    if (d_gnt !== 1 || q_mem !== 2'd1) begin
      errors++; $display("FAIL rom11_d: d_gnt=%b mem=%0d required 1/1", d_gnt, q_mem);
    end
    d_req = 0; q_done = 1;
    advance();
    q_done = 0;
    advance();
  endtask

  task automatic test_reset_mid();
    rom_mode = 2'b01; i_req = 1; i_tag = TW'($urandom);
    advance();
    checks++;
    if (i_gnt !== 1) begin
      errors++; $display("FAIL rmid_grant: i_gnt=%b required 1", i_gnt);
    end
    #2 reset = 1'b0; q_done = 1;
    #1;
    checks++;
    if ({i_gnt, d_gnt, x_gnt, i_done, d_done, x_done, q_req, busy, q_i_d} !== 9'b0 || q_paddr !== '0) begin
      errors++; $display("FAIL rmid_clear: outs=%b paddr=%h required 0",
                         {i_gnt, d_gnt, x_gnt, i_done, d_done, x_done, q_req, busy, q_i_d}, q_paddr);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1; q_done = 0; i_tag = TW'($urandom);
    advance();
    checks++;
    if (i_gnt !== 1 || q_paddr !== i_tag) begin
      errors++; $display("FAIL rmid_regrant: i_gnt=%b addr=%h required 1 %h", i_gnt, q_paddr, i_tag);
    end
    i_req = 0; q_done = 1;
    advance();
    q_done = 0;
    advance();
  endtask

  task automatic test_spurious_drop();
    q_done = 1; #1;
    checks++;
    if ({i_done, d_done, x_done} !== 3'b0) begin
      errors++; $display("FAIL spur_done: got %b required 000", {i_done, d_done, x_done});
    end
    advance();
    q_done = 0;
    checks++;
    if (q_req !== 0 || busy !== 0) begin
      errors++; $display("FAIL spur_state: q_req=%b busy=%b required 0/0", q_req, busy);
    end
    d_req = 1; d_write = 0; d_tag = TW'($urandom);
    advance();
    d_req = 0;
    repeat (2) advance();
    checks++;
    if (d_gnt !== 1 || q_req !== 1) begin
      errors++; $display("FAIL drop_hold: d_gnt=%b q_req=%b required 1/1", d_gnt, q_req);
    end
    q_done = 1; #1;
    checks++;
    if (d_done !== 1) begin
      errors++; $display("FAIL drop_done: d_done=%b required 1", d_done);
    end
    advance();
    q_done = 0;
    advance();
  endtask

  task automatic test_random();
    logic [2:0] ed;
    for (int c = 0; c < 600; c++) begin
      i_req = ($urandom_range(0, 3) != 0); d_req = ($urandom_range(0, 2) == 0);
      x_req = ($urandom_range(0, 4) == 0);
      d_write = 1'($urandom); x_write = 1'($urandom);
      i_tag = TW'($urandom); d_tag = TW'($urandom); x_tag = TW'($urandom);
      q_done = ($urandom_range(0, 3) == 0);
      if (m_owner < 0) rom_mode = 2'($urandom);
      #1;
      ed = '0;
      if (m_owner >= 0 && q_done) ed[m_owner] = 1'b1;
      checks++;
      if ({x_done, d_done, i_done} !== ed || q_mem !== exp_mem()) begin
        errors++; $display("FAIL rnd_comb c=%0d: done=%b mem=%0d required %b %0d",
                           c, {x_done, d_done, i_done}, q_mem, ed, exp_mem());
      end
      advance();
      checks++;
      if ({x_gnt, d_gnt, i_gnt} !== ((m_owner >= 0) ? 3'(1 << m_owner) : 3'b0) ||
          q_req !== (m_owner >= 0) || busy !== (m_owner >= 0) ||
          q_i_d !== (m_owner == 0) || q_write !== ((m_owner >= 0) && m_write) ||
          (m_owner >= 0 && q_paddr !== m_tag)) begin
        errors++; $display("FAIL rnd_reg c=%0d: gnt=%b req=%b busy=%b id=%b wr=%b addr=%h required owner %0d wr=%b addr=%h",
                           c, {x_gnt, d_gnt, i_gnt}, q_req, busy, q_i_d, q_write, q_paddr,
                           m_owner, m_write, m_tag);
      end
    end
    idle_inputs();
    repeat (3) advance();
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_d_over_i();
    test_starvation();
    test_rom11();
    test_reset_mid();
    test_spurious_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
